// File: rtl/rocket_axi_mem_xbar.sv
// rtl/rocket_axi_mem_xbar.sv - AXI4 slave terminating into NUM_CH base/mask-decoded memory request ports
module rocket_axi_mem_xbar #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 2,
    parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_BASE = '0,
    parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_MASK = '0
) (
    input  logic                       clock,
    input  logic                       reset_wire_reset,
    input  logic                       axi_aw_valid,
    output logic                       axi_aw_ready,
    input  logic [ID_WIDTH-1:0]        axi_aw_id,
    input  logic [ADDR_WIDTH-1:0]      axi_aw_addr,
    input  logic [7:0]                 axi_aw_len,
    input  logic [2:0]                 axi_aw_size,
    input  logic [1:0]                 axi_aw_burst,
    input  logic                       axi_aw_lock,
    input  logic [3:0]                 axi_aw_cache,
    input  logic [2:0]                 axi_aw_prot,
    input  logic [3:0]                 axi_aw_qos,
    input  logic                       axi_w_valid,
    output logic                       axi_w_ready,
    input  logic [DATA_WIDTH-1:0]      axi_w_data,
    input  logic [DATA_WIDTH/8-1:0]    axi_w_strb,
    input  logic                       axi_w_last,
    output logic                       axi_b_valid,
    input  logic                       axi_b_ready,
    output logic [ID_WIDTH-1:0]        axi_b_id,
    output logic [1:0]                 axi_b_resp,
    input  logic                       axi_ar_valid,
    output logic                       axi_ar_ready,
    input  logic [ID_WIDTH-1:0]        axi_ar_id,
    input  logic [ADDR_WIDTH-1:0]      axi_ar_addr,
    input  logic [7:0]                 axi_ar_len,
    input  logic [2:0]                 axi_ar_size,
    input  logic [1:0]                 axi_ar_burst,
    input  logic                       axi_ar_lock,
    input  logic [3:0]                 axi_ar_cache,
    input  logic [2:0]                 axi_ar_prot,
    input  logic [3:0]                 axi_ar_qos,
    output logic                       axi_r_valid,
    input  logic                       axi_r_ready,
    output logic [ID_WIDTH-1:0]        axi_r_id,
    output logic [DATA_WIDTH-1:0]      axi_r_data,
    output logic [1:0]                 axi_r_resp,
    output logic                       axi_r_last,
    output logic [NUM_CH-1:0]          mem_req_o,
    output logic                       mem_we_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]    mem_strb_o,
    output logic [DATA_WIDTH-1:0]      mem_data_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0] mem_data_i
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG_BYTES = $clog2(STRB_W);

    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_CAP, S_RD_RESP, S_WR_DATA, S_WR_RESP} state_t;

    state_t                  state_q;
    logic                    last_rd_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, beat_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [NUM_CH-1:0]       hit_q;
    logic                    miss_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rd_sel;

    logic                    ar_grant, aw_grant, rd_req, wr_beat, mem_active;
    logic [ID_WIDTH-1:0]     acc_id;
    logic [ADDR_WIDTH-1:0]   acc_addr, step, wrap_mask, incr;
    logic [7:0]              acc_len;
    logic [2:0]              acc_size;
    logic [1:0]              acc_burst;
    logic [NUM_CH-1:0]       acc_hit;

    logic unused_ok;
    assign unused_ok = ^{axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_qos,
                         axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_qos, axi_w_last};

    // Lowest-index channel wins when several base/mask pairs match.
    function automatic logic [NUM_CH-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [NUM_CH-1:0] hit;
        hit = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if ((a & CH_MASK[c*ADDR_WIDTH +: ADDR_WIDTH]) == CH_BASE[c*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit    = '0;
                hit[c] = 1'b1;
            end
        end
        return hit;
    endfunction

    // Sizes wider than the data bus behave as full-width beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > 3'(LG_BYTES)) ? 3'(LG_BYTES) : s;
    endfunction

    // When both request types are pending, serve the one not served last.
    assign ar_grant = (state_q == S_IDLE) && axi_ar_valid && (!axi_aw_valid || !last_rd_q);
    assign aw_grant = (state_q == S_IDLE) && axi_aw_valid && (!axi_ar_valid || last_rd_q);
    assign axi_ar_ready = ar_grant;
    assign axi_aw_ready = aw_grant;

    // Select the fields of whichever address channel is being accepted.
    always_comb begin
        acc_id    = ar_grant ? axi_ar_id    : axi_aw_id;
        acc_addr  = ar_grant ? axi_ar_addr  : axi_aw_addr;
        acc_len   = ar_grant ? axi_ar_len   : axi_aw_len;
        acc_size  = ar_grant ? axi_ar_size  : axi_aw_size;
        acc_burst = ar_grant ? axi_ar_burst : axi_aw_burst;
        acc_hit   = decode(acc_addr);
    end

    // Next beat address: FIXED holds, WRAP folds into the (len+1)<<size window, others increment.
    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        incr      = addr_q + step;
        case (burst_q)
            2'b00:   addr_d = addr_q;
            2'b10:   addr_d = (addr_q & ~wrap_mask) | (incr & wrap_mask);
            default: addr_d = incr;
        endcase
    end

    // Read data of the decoded channel; all zero on a miss since no hit bit is set.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit_q[c]) rd_sel = rd_sel | mem_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_req     = (state_q == S_RD_REQ);
    assign wr_beat    = (state_q == S_WR_DATA) && axi_w_valid;
    assign mem_active = rd_req || wr_beat;
    assign mem_req_o  = mem_active ? hit_q : '0;
    assign mem_we_o   = wr_beat;
    assign mem_addr_o = mem_active ? (addr_q & ~ADDR_WIDTH'(STRB_W - 1)) : '0;
    assign mem_strb_o = wr_beat ? axi_w_strb : '0;
    assign mem_data_o = wr_beat ? axi_w_data : '0;

    assign axi_w_ready = (state_q == S_WR_DATA);
    assign axi_r_valid = (state_q == S_RD_RESP);
    assign axi_r_id    = id_q;
    assign axi_r_data  = rdata_q;
    assign axi_r_resp  = (axi_r_valid && miss_q) ? 2'b11 : 2'b00;
    assign axi_r_last  = axi_r_valid && (beat_q == len_q);
    assign axi_b_valid = (state_q == S_WR_RESP);
    assign axi_b_id    = id_q;
    assign axi_b_resp  = (axi_b_valid && miss_q) ? 2'b11 : 2'b00;

    // Transaction FSM: one burst in flight, decode latched on the first beat only.
    always_ff @(posedge clock or posedge reset_wire_reset) begin
        if (reset_wire_reset) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            hit_q     <= '0;
            miss_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ar_grant || aw_grant) begin
                        id_q      <= acc_id;
                        addr_q    <= acc_addr;
                        len_q     <= acc_len;
                        size_q    <= clamp_size(acc_size);
                        burst_q   <= acc_burst;
                        beat_q    <= '0;
                        hit_q     <= acc_hit;
                        miss_q    <= (acc_hit == '0);
                        last_rd_q <= ar_grant;
                        state_q   <= ar_grant ? S_RD_REQ : S_WR_DATA;
                    end
                end
                S_RD_REQ: state_q <= S_RD_CAP;
                S_RD_CAP: begin
                    rdata_q <= rd_sel;
                    state_q <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (axi_r_ready) begin
                        addr_q <= addr_d;
                        if (beat_q == len_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (axi_w_valid) begin
                        addr_q <= addr_d;
                        if (beat_q == len_q) state_q <= S_WR_RESP;
                        else beat_q <= beat_q + 8'd1;
                    end
                end
                S_WR_RESP: if (axi_b_ready) state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/rocket_axi_mem_xbar.md
# rocket_axi_mem_xbar

Parametrised successor to the single-target AXI4-to-memory bridge. It terminates one AXI4 slave port from the Rocket ChipTop and routes each transaction to one of NUM_CH simple memory request ports, decoded by base/mask. Unlike the previous bridge, it supports FIXED/INCR/WRAP bursts up to 256 beats, arbitrates fairly between reads and writes, and returns DECERR for unmapped addresses. It sits between ChipTop's axi4_mem/axi4_mmio ports and the testbench memories/MMIO devices.

## Interface
Parameters:
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, AXI and memory address width
- DATA_WIDTH, 64, data width (power of two, >= 32)
- NUM_CH, 2, number of memory request ports (1..8)
- CH_BASE, {NUM_CH{32'h0}}, packed NUM_CH*ADDR_WIDTH base addresses; channel c hits when (addr & CH_MASK[c]) == CH_BASE[c]
- CH_MASK, {NUM_CH{32'h0}}, packed NUM_CH*ADDR_WIDTH masks; lowest index wins on overlap

Ports (reset is asynchronous, active-high):
- clock  in  1  sole clock
- reset_wire_reset  in  1  asynchronous active-high reset
- axi_aw_*  in/out  AXI4 AW channel: valid in, ready out, id/addr/len[7:0]/size[2:0]/burst[1:0] in (lock/cache/prot/qos in, ignored)
- axi_w_*  in/out  valid/data/strb/last in, ready out
- axi_b_*  in/out  valid/id/resp[1:0] out, ready in
- axi_ar_*  in/out  same fields as AW
- axi_r_*  in/out  valid/id/data/resp/last out, ready in
- mem_req_o  out  NUM_CH  one-hot request strobe per channel
- mem_we_o  out  1  write enable (shared)
- mem_addr_o  out  ADDR_WIDTH  beat address, low log2(DATA_WIDTH/8) bits zero (shared)
- mem_strb_o  out  DATA_WIDTH/8  byte enables (shared)
- mem_data_o  out  DATA_WIDTH  write data (shared)
- mem_data_i  in  NUM_CH*DATA_WIDTH  read data per channel, valid the cycle after mem_req_o

## Operation
- One transaction in flight. FSM: IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP.
- IDLE: if only AR valid -> ar_ready=1; only AW valid -> aw_ready=1; both -> grant the type not served last (last_rd flag; reset value: writes win first). On accept latch id, addr, len, size, burst, hit channel (or miss) and go to RD_REQ / WR_DATA.
- RD_REQ: assert mem_req_o[ch] (none on miss), we=0 -> RD_CAP.
- RD_CAP: register mem_data_i[ch] (0 on miss) into R buffer -> RD_RESP.
- RD_RESP: r_valid=1, r_resp=OKAY(00) or DECERR(11), r_last on beat len; on r_ready advance address; last -> IDLE else RD_REQ.
- WR_DATA: w_ready=1; on w_valid, same cycle assert mem_req_o[ch] with we=1, data/strb from W (no req on miss); advance address; beat len -> WR_RESP. w_last is ignored; beat count from len governs.
- WR_RESP: b_valid=1, b_id, b_resp OKAY or DECERR (any miss); on b_ready -> IDLE.
- Address update per beat: FIXED unchanged; INCR addr += 1<<size; WRAP increments then wraps within (len+1)<<size aligned window; burst 2'b11 treated as INCR. Arithmetic is ADDR_WIDTH-bit, wraps modulo 2^ADDR_WIDTH. Channel decode is done once on the first beat only.
- size > log2(DATA_WIDTH/8) is clamped to full width.

## Timing
- Reset: state IDLE, all valid/ready/req/we outputs 0, addr/data/strb 0, r/b id/resp 0, last_rd=1.
- Read beat: req cycle N, data captured edge N+1, r_valid from N+2; minimum 3 cycles/beat; first req one cycle after AR handshake.
- Write beat: mem_req in the W handshake cycle; b_valid the cycle after last beat.
- r_valid/b_valid held with stable payload until ready; ready never depends on valid of the same channel except IDLE arbitration.
- Reset asserted mid-burst: abort immediately, no further mem_req, no B/R response.

## Test plan
- Single read, ch0 base 0x8000_0000 mask 0xF000_0000, addr 0x8000_0010 -> one mem_req_o=01 with addr 0x8000_0010, R data = mem_data_i, resp 00, last=1, 3 cycles from AR.
- INCR write len=3 size=3 addr 0x8000_0000 -> four reqs at 0x00/08/10/18, we=1, strb per beat, one B OKAY with matching id.
- WRAP read len=3 size=3 addr 0x8000_0018 -> addresses 0x18, 0x00, 0x08, 0x10.
- Unmapped addr 0x1000_0000 write len=1 -> no mem_req, two W beats accepted, b_resp=11; read -> data 0, resp 11 on every beat, last on beat 2.
- AR and AW valid together from reset -> write served first, then read; repeated simultaneity alternates.
- r_ready held low 5 cycles mid-burst -> r_valid/data stable, no new mem_req until handshake; reset mid-burst -> all outputs 0 next cycle, next AR accepted normally.
